baud_ctrl: RTL and testbench

Controller for the UART baud timer (a 16x-oversampling tick counter with `enable`, `FINAL_VALUE` and `tick`, and no synchronous clear). It owns the timer's `enable` and `FINAL_VALUE` inputs and accepts run-time divisor changes through a pulse/ack handshake. It defers each change until the TX/RX link is idle, then flushes the timer to a known phase and restarts it. It also derives gated sample ticks and a divide-by-16 bit tick for the transmitter and receiver FSMs.

---
 rtl/baud_ctrl_if.sv | 13 +
 rtl/baud_ctrl.sv | 91 +++++++++
 tb/tb_baud_ctrl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/baud_ctrl_if.sv
// Divisor-change handshake between the UART configuration master and baud_ctrl.
interface baud_ctrl_if #(
  parameter int BITS = 11
);
  logic            cfg_req;
  logic [BITS-1:0] cfg_div;
  logic            cfg_busy;
  logic            cfg_ack;
  logic            cfg_err;

  modport master (output cfg_req, cfg_div, input cfg_busy, cfg_ack, cfg_err);
  modport slave  (input cfg_req, cfg_div, output cfg_busy, cfg_ack, cfg_err);
endinterface

// File: rtl/baud_ctrl.sv
// Baud timer controller: defers divisor changes until the link is idle, flushes the
// timer phase, and derives gated 16x sample ticks and a divide-by-16 bit tick.
module baud_ctrl #(
  parameter int BITS        = 11,
  parameter int DEFAULT_DIV = 650,
  parameter int MIN_DIV     = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  baud_ctrl_if.slave      cfg,
  input  logic            link_busy,
  input  logic            os_clr,
  input  logic            tick,
  output logic            timer_enable,
  output logic [BITS-1:0] final_value,
  output logic [BITS-1:0] div_active,
  output logic            sample_tick,
  output logic            bit_tick
);

  typedef enum logic [1:0] {RUN, DRAIN, FLUSH} state_t;

  state_t          state, state_nxt;
  logic [BITS-1:0] div_pend;
  logic [3:0]      os_cnt;
  logic            accept, reject;
  logic            sample_evt;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    reject    = 1'b0;
    unique case (state)
      RUN: begin
        if (cfg.cfg_req) begin
          if (cfg.cfg_div >= BITS'(MIN_DIV)) begin
            accept    = 1'b1;
            state_nxt = DRAIN;
          end else begin
            reject = 1'b1;
          end
        end
      end
      DRAIN: begin
        reject = cfg.cfg_req;
        if (!link_busy) state_nxt = FLUSH;
      end
      FLUSH: begin
        reject    = cfg.cfg_req;
        state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // A tick landing in the flush cycle belongs to the discarded timer phase.
  assign sample_evt = tick && (state != FLUSH);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= RUN;
      div_pend     <= BITS'(DEFAULT_DIV);
      div_active   <= BITS'(DEFAULT_DIV);
      final_value  <= BITS'(DEFAULT_DIV);
      timer_enable <= 1'b1;
      cfg.cfg_busy <= 1'b0;
      cfg.cfg_ack  <= 1'b0;
      cfg.cfg_err  <= 1'b0;
      sample_tick  <= 1'b0;
      bit_tick     <= 1'b0;
      os_cnt       <= '0;
    end else begin
      state        <= state_nxt;
      timer_enable <= 1'b1;
      cfg.cfg_busy <= (state_nxt != RUN);
      cfg.cfg_ack  <= (state == FLUSH);
      cfg.cfg_err  <= reject;
      if (accept) div_pend <= cfg.cfg_div;
      if (state == FLUSH) div_active <= div_pend;
      // Terminal value 0 during the flush cycle wraps the timer to Q=0 at its end.
      if (state_nxt == FLUSH)  final_value <= '0;
      else if (state == FLUSH) final_value <= div_pend;
      else                     final_value <= div_active;
      sample_tick <= sample_evt;
      bit_tick    <= sample_evt && !os_clr && (os_cnt == 4'hF);
      if (os_clr || (state == FLUSH)) os_cnt <= '0;
      else if (sample_evt)            os_cnt <= os_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_baud_ctrl.sv
// Directed bench for baud_ctrl with a timer model and a cycle-level period/latency model.
module tb_baud_ctrl;
  localparam int BITS = 8;
  localparam int DEF  = 9;
  localparam int MINV = 1;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            link_busy = 1'b0;
  logic            os_clr = 1'b0;
  logic            tick;
  logic            timer_enable, sample_tick, bit_tick;
  logic [BITS-1:0] final_value, div_active, q;

  baud_ctrl_if #(.BITS(BITS)) cfg ();

  baud_ctrl #(.BITS(BITS), .DEFAULT_DIV(DEF), .MIN_DIV(MINV)) dut (
    .clk(clk), .reset_n(reset_n), .cfg(cfg), .link_busy(link_busy), .os_clr(os_clr),
    .tick(tick), .timer_enable(timer_enable), .final_value(final_value),
    .div_active(div_active), .sample_tick(sample_tick), .bit_tick(bit_tick)
  );

  always #5 clk = ~clk;

  // Baud timer: counts up, wraps to 0 once Q reaches or passes FINAL_VALUE.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)          q <= '0;
    else if (timer_enable) q <= (q >= final_value) ? '0 : q + 1'b1;
  end
  assign tick = (q == final_value);

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Model state: expected event times derived from divisor periods.
  int cyc = 0;
  bit in_reset = 1'b1;
  int div_cur, next_st, cnt, ack_at, acc_c, pend_div, err_at;
  bit pend, clr_prev;
  // Observations used by the directed checks.
  int last_st = -1000, st_gap = 0, last_bit = -1000, bit_gap = 0;
  int last_ack = -1, last_err = -1, first_after_ack = -1;
  int busy_run = 0, last_busy_len = 0;
  bit need_first = 1'b0;

  always @(negedge clk) begin : compare
    int t;
    bit e_st, e_bit, e_busy, e_ack, e_err;
    int e_fv;
    t = cyc;
    if (!reset_n) begin
      in_reset = 1'b1;
    end else begin
      if (in_reset) begin
        in_reset = 1'b0;
        div_cur = DEF; next_st = t + DEF + 1; cnt = 0; ack_at = -1; pend = 1'b0;
        err_at = -1; clr_prev = 1'b0; need_first = 1'b0; last_st = -1000;
        last_bit = -1000; busy_run = 0;
      end
      if (pend && t == ack_at) begin
        div_cur = pend_div; next_st = t + div_cur + 1; cnt = 0; pend = 1'b0;
      end
      e_st   = (t == next_st);
      e_bit  = e_st && !clr_prev && (cnt == 15);
      e_busy = pend && (t > acc_c);
      e_ack  = (t == ack_at);
      e_err  = (t == err_at);
      e_fv   = (pend && ack_at >= 0 && t == ack_at - 1) ? 0 : div_cur;

      chk("sample_tick", sample_tick, e_st);
      chk("bit_tick", bit_tick, e_bit);
      chk("cfg_busy", cfg.cfg_busy, e_busy);
      chk("cfg_ack", cfg.cfg_ack, e_ack);
      chk("cfg_err", cfg.cfg_err, e_err);
      chk("div_active", div_active, div_cur);
      chk("final_value", final_value, e_fv);
      chk("timer_enable", timer_enable, 1);

      if (cfg.cfg_ack) begin last_ack = t; need_first = 1'b1; end
      if (sample_tick) begin
        st_gap = t - last_st; last_st = t;
        if (need_first) begin first_after_ack = t; need_first = 1'b0; end
      end
      if (bit_tick) begin bit_gap = t - last_bit; last_bit = t; end
      if (cfg.cfg_err) last_err = t;
      if (cfg.cfg_busy) busy_run++;
      else if (busy_run > 0) begin last_busy_len = busy_run; busy_run = 0; end

      if (e_st) begin
        next_st = next_st + div_cur + 1;
        cnt = clr_prev ? 0 : (cnt + 1) % 16;
      end else if (clr_prev) begin
        cnt = 0;
      end
      clr_prev = os_clr;
      if (cfg.cfg_req) begin
        if (pend || int'(cfg.cfg_div) < MINV) err_at = t + 1;
        else begin pend = 1'b1; acc_c = t; pend_div = int'(cfg.cfg_div); ack_at = -1; end
      end
      if (pend && ack_at < 0 && t >= acc_c + 1 && !link_busy) ack_at = t + 2;
    end
    cyc++;
  end

  task automatic tick_n(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input int div, output int rc);
    cfg.cfg_req = 1'b1;
    cfg.cfg_div = BITS'(div);
    rc = cyc;
    tick_n(1);
    cfg.cfg_req = 1'b0;
  endtask

  task automatic wait_ack(input int lim);
    int start;
    start = cyc;
    for (int i = 0; i < lim && last_ack < start; i++) tick_n(1);
    if (last_ack < start) chk("ack_timeout", 0, 1);
  endtask

  task automatic wait_bit(input int lim);
    int start;
    start = cyc;
    for (int i = 0; i < lim && last_bit < start; i++) tick_n(1);
    if (last_bit < start) chk("bit_timeout", 0, 1);
  endtask

  task automatic wait_until(input int target);
    for (int i = 0; i < 400 && cyc < target; i++) tick_n(1);
    if (cyc != target) chk("wait_target", cyc, target);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, cfg.cfg_busy, 0);
    chk({tag, "_ack"}, cfg.cfg_ack, 0);
    chk({tag, "_err"}, cfg.cfg_err, 0);
    chk({tag, "_st"}, sample_tick, 0);
    chk({tag, "_bit"}, bit_tick, 0);
    chk({tag, "_div"}, div_active, 9);
    chk({tag, "_fv"}, final_value, 9);
    chk({tag, "_en"}, timer_enable, 1);
  endtask

  initial begin : stim
    int rc, rc2, fc, clr_c, rst_c;
    cfg.cfg_req = 1'b0;
    cfg.cfg_div = '0;
    tick_n(3);
    chk_reset_vals("rst");
    reset_n = 1'b1;

    // Default divisor 9: period 10, bit every 160.
    tick_n(335);
    chk("st_period_def", st_gap, 10);
    chk("bit_period_def", bit_gap, 160);
    chk("div_def", div_active, 9);

    // Idle change to 4.
    send(4, rc);
    wait_ack(20);
    chk("ack_latency", last_ack - rc, 3);
    chk("busy_len", last_busy_len, 2);
    tick_n(15);
    chk("first_st_after_ack", first_after_ack - last_ack, 5);
    chk("st_period_4", st_gap, 5);
    chk("div_4", div_active, 4);

    send(9, rc);
    wait_ack(20);
    tick_n(25);

    // Deferred change while the link is busy.
    link_busy = 1'b1;
    tick_n(20);
    send(4, rc);
    tick_n(30);
    chk("drain_busy", cfg.cfg_busy, 1);
    chk("drain_period", st_gap, 10);
    chk("drain_div", div_active, 9);
    link_busy = 1'b0;
    fc = cyc;
    wait_ack(20);
    chk("defer_latency", last_ack - fc, 2);
    tick_n(12);
    chk("defer_first_st", first_after_ack - last_ack, 5);

    // Rejects.
    send(0, rc);
    tick_n(2);
    chk("err_zero", last_err - rc, 1);
    chk("div_after_err", div_active, 4);
    link_busy = 1'b1;
    send(7, rc);
    send(3, rc2);
    tick_n(2);
    chk("err_during_drain", last_err - rc2, 1);
    link_busy = 1'b0;
    wait_ack(20);
    tick_n(2);
    chk("div_first_wins", div_active, 7);

    // Resync with period 8: clear on the 8th sample tick after a bit tick.
    wait_bit(300);
    clr_c = last_bit + 64;
    wait_until(clr_c);
    os_clr = 1'b1;
    tick_n(1);
    os_clr = 1'b0;
    wait_bit(300);
    chk("resync_bit", last_bit - clr_c, 128);
    // Clear on the tick cycle itself: that event is dropped.
    clr_c = last_bit + 63;
    wait_until(clr_c);
    os_clr = 1'b1;
    tick_n(1);
    os_clr = 1'b0;
    wait_bit(300);
    chk("resync_prio_bit", last_bit - clr_c, 129);

    // Reset during DRAIN.
    link_busy = 1'b1;
    send(3, rc);
    tick_n(3);
    reset_n = 1'b0;
    #1;
    chk_reset_vals("rst_drain");
    rst_c = cyc;
    tick_n(2);
    reset_n = 1'b1;
    link_busy = 1'b0;
    tick_n(35);
    chk("rst_period", st_gap, 10);
    chk("no_ack_after_rst", (last_ack >= rst_c) ? 1 : 0, 0);
    chk("rst_div", div_active, 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
